// File: rtl/ftdi_sync_fifo_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ftdi_sync_fifo_writer: drains the packetizer byte FIFO into an FT2232H   |
// | synchronous 245 FIFO port, with a 2-entry skid buffer and SIWU# flush.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ftdi_sync_fifo_writer #(
  parameter int FLUSH_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             fifo_empty_i,
  output logic             fifo_req_o,
  input  logic [7:0]       fifo_data_i,
  input  logic             ftdi_txe_n_i,
  output logic             ftdi_wr_n_o,
  output logic [7:0]       ftdi_data_o,
  output logic             ftdi_siwu_n_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] byte_count_o
);

  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_stream = 2'd1;
  localparam logic [1:0]  c_st_siwu   = 2'd2;
  localparam logic [15:0] c_cnt_last  = 16'(FLUSH_TIMEOUT - 1);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [7:0]       r_buf0;
  logic [7:0]       r_buf1;
  logic             r_wr_n;
  logic [7:0]       r_data;
  logic             r_siwu_n;
  logic             r_busy;
  logic [CNT_W-1:0] r_byte_count;
  logic [1:0]       r_state;
  logic [15:0]      r_idle_cnt;

  logic             w_req;
  logic             w_accept;
  logic [1:0]       w_occ_next;
  logic [7:0]       w_buf0_next;
  logic [7:0]       w_buf1_next;

  // Credit check ignores a pop in the same cycle, so occ+inflight never exceeds 2.
  assign w_req    = en_i & ~fifo_empty_i & (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);
  assign w_accept = ~r_wr_n & ~ftdi_txe_n_i;

  always_comb begin
    w_occ_next  = r_occ;
    w_buf0_next = r_buf0;
    w_buf1_next = r_buf1;
    case ({w_accept, r_inflight})
      2'b01: begin
        w_occ_next = r_occ + 2'd1;
        if (r_occ == 2'd0) w_buf0_next = fifo_data_i;
        else               w_buf1_next = fifo_data_i;
      end
      2'b10: begin
        w_occ_next  = r_occ - 2'd1;
        w_buf0_next = r_buf1;
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          w_buf0_next = fifo_data_i;
        end else begin
          w_buf0_next = r_buf1;
          w_buf1_next = fifo_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_buf0       <= 8'h00;
      r_buf1       <= 8'h00;
      r_wr_n       <= 1'b1;
      r_data       <= 8'h00;
      r_busy       <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= w_req;
      r_buf0     <= w_buf0_next;
      r_buf1     <= w_buf1_next;
      // WR# and data always present the post-edge head, so a refused byte is re-offered.
      r_wr_n     <= ~(~ftdi_txe_n_i & (w_occ_next != 2'd0));
      r_data     <= w_buf0_next;
      r_busy     <= (w_occ_next != 2'd0) | w_req;
      if (w_accept) r_byte_count <= r_byte_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= c_st_idle;
      r_idle_cnt <= 16'd0;
      r_siwu_n   <= 1'b1;
    end else begin
      r_siwu_n <= 1'b1;
      case (r_state)
        c_st_idle: begin
          r_idle_cnt <= 16'd0;
          if (w_accept) r_state <= c_st_stream;
        end
        c_st_stream: begin
          if (w_accept | r_busy) begin
            r_idle_cnt <= 16'd0;
          end else if (r_idle_cnt == c_cnt_last) begin
            r_state    <= c_st_siwu;
            r_siwu_n   <= 1'b0;
            r_idle_cnt <= 16'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
        end
        c_st_siwu: begin
          r_state    <= c_st_idle;
          r_idle_cnt <= 16'd0;
        end
        default: begin
          r_state    <= c_st_idle;
          r_idle_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign fifo_req_o    = w_req;
  assign ftdi_wr_n_o   = r_wr_n;
  assign ftdi_data_o   = r_data;
  assign ftdi_siwu_n_o = r_siwu_n;
  assign busy_o        = r_busy;
  assign byte_count_o  = r_byte_count;

endmodule
`default_nettype wire
